// File: rtl/morra_pkg.sv
// Shared types for the parametrised morra cinese match controller.
package morra_pkg;

    typedef enum logic [1:0] {MV_NONE, MV_SASSO, MV_CARTA, MV_FORBICE} move_t;
    typedef enum logic [1:0] {M_NONE, M_P1, M_P2, M_TIE} manche_t;
    typedef enum logic [1:0] {P_NONE, P_P1, P_P2, P_DRAW} partita_t;
    typedef enum logic [1:0] {S_IDLE, S_PLAY, S_END} state_t;

    // Winner of the previous valid round and the move it won with.
    typedef struct packed {
        manche_t who;
        move_t   mv;
    } last_win_t;

    function automatic logic beats(input move_t a, input move_t b);
        return (a == MV_CARTA   && b == MV_SASSO)   ||
               (a == MV_SASSO   && b == MV_FORBICE) ||
               (a == MV_FORBICE && b == MV_CARTA);
    endfunction

endpackage

// File: rtl/morra_cinese_param_judge.sv
// Combinational round judge: move pair -> {valid, result}.
// With NO_REPEAT_EN the previous winner may not replay its winning move.
module morra_judge
    import morra_pkg::*;
(
    input  move_t     p1_i,
    input  move_t     p2_i,
`ifdef NO_REPEAT_EN
    input  last_win_t forbid_i,
`endif
    output logic      valid_o,
    output manche_t   result_o
);

    always_comb begin
        valid_o  = 1'b1;
        result_o = M_NONE;
        if (p1_i == MV_NONE || p2_i == MV_NONE) begin
            valid_o = 1'b0;
`ifdef NO_REPEAT_EN
        end else if ((forbid_i.who == M_P1 && p1_i == forbid_i.mv) ||
                     (forbid_i.who == M_P2 && p2_i == forbid_i.mv)) begin
            valid_o = 1'b0;
`endif
        end else if (p1_i == p2_i) begin
            result_o = M_TIE;
        end else if (beats(p1_i, p2_i)) begin
            result_o = M_P1;
        end else begin
            result_o = M_P2;
        end
    end

endmodule

// File: rtl/morra_cinese_param.sv
// Morra cinese match controller: configurable round limit, lead-based early end.
// Optional NO_REPEAT_EN forbids a round winner from replaying its winning move.
module morra_cinese_param
    import morra_pkg::*;
#(
    parameter int MIN_MANCHE = 4,
    parameter int CFG_W      = 4,
    parameter int LEAD       = 2,
    parameter int CNT_W      = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       INIZIO,
    input  logic [1:0] PRIMO,
    input  logic [1:0] SECONDO,
    output logic [1:0] MANCHE,
    output logic [1:0] PARTITA
);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   max_r_q, max_r_d;
    logic [CNT_W-1:0]   played_q, played_d;
    logic [CNT_W-1:0]   w1_q, w1_d;
    logic [CNT_W-1:0]   w2_q, w2_d;
    manche_t            manche_q, manche_d;
    partita_t           partita_q, partita_d;

    logic [CFG_W-1:0]   cfg;
    logic [CNT_W-1:0]   diff_c;
    logic               valid;
    manche_t            result;

    assign cfg = {PRIMO, SECONDO};

`ifdef NO_REPEAT_EN
    last_win_t last_q, last_d;
`endif

    morra_judge u_judge (
        .p1_i     (move_t'(PRIMO)),
        .p2_i     (move_t'(SECONDO)),
`ifdef NO_REPEAT_EN
        .forbid_i (last_q),
`endif
        .valid_o  (valid),
        .result_o (result)
    );

    // NOTE: every _d gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        state_d   = state_q;
        max_r_d   = max_r_q;
        played_d  = played_q;
        w1_d      = w1_q;
        w2_d      = w2_q;
        manche_d  = manche_q;
        partita_d = partita_q;
        diff_c    = '0;
`ifdef NO_REPEAT_EN
        last_d    = last_q;
`endif

        if (INIZIO) begin
            // Restart from any state; wins over judging in PLAY.
            state_d   = S_PLAY;
            max_r_d   = CNT_W'(MIN_MANCHE) + CNT_W'(cfg);
            played_d  = '0;
            w1_d      = '0;
            w2_d      = '0;
            manche_d  = M_NONE;
            partita_d = P_NONE;
`ifdef NO_REPEAT_EN
            last_d    = '0;
`endif
        end else if (state_q == S_PLAY) begin
            manche_d = result;
            if (valid) begin
                played_d = played_q + CNT_W'(1);
                if (result == M_P1) w1_d = w1_q + CNT_W'(1);
                if (result == M_P2) w2_d = w2_q + CNT_W'(1);
            end
`ifdef NO_REPEAT_EN
            if (valid && (result == M_P1 || result == M_P2)) begin
                last_d.who = result;
                last_d.mv  = (result == M_P1) ? move_t'(PRIMO) : move_t'(SECONDO);
            end else begin
                last_d = '0;
            end
`endif
            diff_c = (w1_d >= w2_d) ? (w1_d - w2_d) : (w2_d - w1_d);
            if (played_d >= CNT_W'(MIN_MANCHE) && diff_c >= CNT_W'(LEAD)) begin
                partita_d = (w1_d > w2_d) ? P_P1 : P_P2;
                state_d   = S_END;
            end else if (played_d == max_r_q) begin
                partita_d = (w1_d > w2_d) ? P_P1 :
                            (w2_d > w1_d) ? P_P2 : P_DRAW;
                state_d   = S_END;
            end
        end else if (state_q == S_IDLE) begin
            manche_d = M_NONE;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            max_r_q   <= '0;
            played_q  <= '0;
            w1_q      <= '0;
            w2_q      <= '0;
            manche_q  <= M_NONE;
            partita_q <= P_NONE;
`ifdef NO_REPEAT_EN
            last_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            max_r_q   <= max_r_d;
            played_q  <= played_d;
            w1_q      <= w1_d;
            w2_q      <= w2_d;
            manche_q  <= manche_d;
            partita_q <= partita_d;
`ifdef NO_REPEAT_EN
            last_q    <= last_d;
`endif
        end
    end

    assign MANCHE  = manche_q;
    assign PARTITA = partita_q;

endmodule

// File: tb/tb_morra_cinese_param.sv
// Directed table-driven bench for morra_cinese_param (MIN_MANCHE=4, LEAD=2).
module tb_morra_cinese_param;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       INIZIO = 1'b0;
    logic [1:0] PRIMO = 2'b00;
    logic [1:0] SECONDO = 2'b00;
    logic [1:0] MANCHE;
    logic [1:0] PARTITA;

    int n_applied = 0;
    int n_miss = 0;

    morra_cinese_param dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .INIZIO  (INIZIO),
        .PRIMO   (PRIMO),
        .SECONDO (SECONDO),
        .MANCHE  (MANCHE),
        .PARTITA (PARTITA)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       ini;
        logic [1:0] p1;
        logic [1:0] p2;
        logic [1:0] em;
        logic [1:0] ep;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic ini, input logic [1:0] p1, input logic [1:0] p2,
                                input logic [1:0] em, input logic [1:0] ep);
        vec_t v;
        v.ini = ini; v.p1 = p1; v.p2 = p2; v.em = em; v.ep = ep;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
        n_applied++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic apply(input logic ini, input logic [1:0] p1, input logic [1:0] p2);
        @(negedge clk);
        INIZIO = ini; PRIMO = p1; SECONDO = p2;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Idle after reset ignores moves
        add(0, 2'b10, 2'b01, 2'b00, 2'b00);
        // Max 4, P1 wins every round; lead reached but ends only at round 4
        add(1, 2'b00, 2'b00, 2'b00, 2'b00);
        add(0, 2'b10, 2'b01, 2'b01, 2'b00);
        add(0, 2'b01, 2'b11, 2'b01, 2'b00);
        add(0, 2'b10, 2'b01, 2'b01, 2'b00);
        add(0, 2'b01, 2'b11, 2'b01, 2'b01);
        add(0, 2'b01, 2'b10, 2'b01, 2'b01);
        // Max 4: P1, P2, tie, tie -> draw
        add(1, 2'b00, 2'b00, 2'b00, 2'b00);
        add(0, 2'b10, 2'b01, 2'b01, 2'b00);
        add(0, 2'b01, 2'b10, 2'b10, 2'b00);
        add(0, 2'b11, 2'b11, 2'b11, 2'b00);
        add(0, 2'b11, 2'b11, 2'b11, 2'b11);
        // Max 4: invalid round does not count
        add(1, 2'b00, 2'b00, 2'b00, 2'b00);
        add(0, 2'b00, 2'b10, 2'b00, 2'b00);
        add(0, 2'b11, 2'b11, 2'b11, 2'b00);
        add(0, 2'b10, 2'b10, 2'b11, 2'b00);
        add(0, 2'b01, 2'b01, 2'b11, 2'b00);
        add(0, 2'b11, 2'b11, 2'b11, 2'b11);
        // Restart mid-match with cfg 0001 clears the old lead
        add(1, 2'b00, 2'b00, 2'b00, 2'b00);
        add(0, 2'b10, 2'b01, 2'b01, 2'b00);
        add(0, 2'b01, 2'b11, 2'b01, 2'b00);
        add(1, 2'b00, 2'b01, 2'b00, 2'b00);
        add(0, 2'b10, 2'b01, 2'b01, 2'b00);
        add(0, 2'b01, 2'b11, 2'b01, 2'b00);
        add(0, 2'b10, 2'b01, 2'b01, 2'b00);
        add(0, 2'b01, 2'b11, 2'b01, 2'b01);
        // Max 5: lead of exactly 2 at round 4 ends the match
        add(1, 2'b00, 2'b01, 2'b00, 2'b00);
        add(0, 2'b10, 2'b01, 2'b01, 2'b00);
        add(0, 2'b01, 2'b11, 2'b01, 2'b00);
        add(0, 2'b11, 2'b11, 2'b11, 2'b00);
        add(0, 2'b11, 2'b11, 2'b11, 2'b01);
        // Max 5: lead of 1 at the limit -> P2 wins
        add(1, 2'b00, 2'b01, 2'b00, 2'b00);
        add(0, 2'b01, 2'b10, 2'b10, 2'b00);
        add(0, 2'b10, 2'b01, 2'b01, 2'b00);
        add(0, 2'b01, 2'b10, 2'b10, 2'b00);
        add(0, 2'b11, 2'b11, 2'b11, 2'b00);
        add(0, 2'b10, 2'b10, 2'b11, 2'b10);
        // Winner replays its winning move
        add(1, 2'b00, 2'b00, 2'b00, 2'b00);
        add(0, 2'b11, 2'b10, 2'b01, 2'b00);
`ifdef NO_REPEAT_EN
        add(0, 2'b11, 2'b01, 2'b00, 2'b00);
`else
        add(0, 2'b11, 2'b01, 2'b10, 2'b00);
`endif

        // Reset held for a few cycles, outputs cleared
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_manche", MANCHE, 2'b00);
        check("reset_partita", PARTITA, 2'b00);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            apply(vecs[i].ini, vecs[i].p1, vecs[i].p2);
            check($sformatf("vec%0d_manche", i), MANCHE, vecs[i].em);
            check($sformatf("vec%0d_partita", i), PARTITA, vecs[i].ep);
        end

        // Asynchronous reset mid-match takes effect without a clock edge
        apply(1, 2'b00, 2'b00);
        apply(0, 2'b11, 2'b11);
        check("pre_async_manche", MANCHE, 2'b11);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_manche", MANCHE, 2'b00);
        check("async_rst_partita", PARTITA, 2'b00);
        @(negedge clk);
        rst_n = 1'b1;
        apply(0, 2'b10, 2'b01);
        check("post_rst_idle_manche", MANCHE, 2'b00);
        check("post_rst_idle_partita", PARTITA, 2'b00);

        // Largest config: 19 rounds of ties, draw only at the 19th
        apply(1, 2'b11, 2'b11);
        for (int r = 1; r <= 18; r++) begin
            apply(0, 2'b01 + 2'(r % 3), 2'b01 + 2'(r % 3));
        end
        check("max19_r18_manche", MANCHE, 2'b11);
        check("max19_r18_partita", PARTITA, 2'b00);
        apply(0, 2'b10, 2'b10);
        check("max19_r19_partita", PARTITA, 2'b11);
        apply(0, 2'b10, 2'b01);
        check("max19_end_hold_manche", MANCHE, 2'b11);
        check("max19_end_hold_partita", PARTITA, 2'b11);

        $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miss);
        $finish;
    end

endmodule

// File: doc/morra_cinese_param.md
Name: morra_cinese_param

Overview:
Parametrised rock-paper-scissors (morra cinese) match controller; successor to the fixed two-player FSMD. Configures the maximum round count at game start and judges one round per clock. Tracks per-player wins. Declares the match winner on a configurable lead or at the round limit. Registered outputs; sits directly under the top-level game wrapper, driven by the player input buses.

Parameters:
MIN_MANCHE, 4, minimum valid rounds before a lead can end the match
CFG_W, 4, width of start-time config word {PRIMO,SECONDO} (must be 4 when moves are 2-bit)
LEAD, 2, win margin that ends the match once MIN_MANCHE is reached
CNT_W, 5, width of round/win counters; must hold MIN_MANCHE + 2^CFG_W - 1

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
INIZIO  in  1  start/restart request; sampled on clk
PRIMO  in  2  player 1 move: 00 none/invalid, 01 sasso, 10 carta, 11 forbice
SECONDO  in  2  player 2 move, same encoding
MANCHE  out  2  last-round result: 00 invalid/none, 01 P1, 10 P2, 11 tie
PARTITA  out  2  match result: 00 in progress/idle, 01 P1, 10 P2, 11 draw

Behaviour:
- Reset: state IDLE; MANCHE=00, PARTITA=00; all counters 0; max_r=0; last-winner-move cleared. Reset applies immediately, even mid-match.
- Latency: outputs are registered and reflect inputs sampled on the previous rising edge (1 cycle).
- States: IDLE, PLAY, END.
- IDLE: moves are ignored; MANCHE=00. If INIZIO=1: max_r <= MIN_MANCHE + {PRIMO,SECONDO} (range 4..19 at defaults); clear counters; go to PLAY.
- PLAY, INIZIO=1: restart with the new config as in IDLE. Takes priority over judging. MANCHE=00, PARTITA=00.
- PLAY, INIZIO=0: judge the round.
  - Invalid if either move is 00. Invalid rounds give MANCHE=00 and change no counters.
  - Otherwise: carta beats sasso, sasso beats forbice, forbice beats carta; equal moves tie.
  - played += 1 on every valid round (ties included); winner's count += 1.
- End check, after the counter update in the same cycle:
  - If played >= MIN_MANCHE and |w1-w2| >= LEAD: PARTITA = leader; go to END.
  - Else if played == max_r: PARTITA = 01 if w1>w2, 10 if w2>w1, 11 if equal; go to END.
- END: PARTITA and the final MANCHE hold. Moves are ignored (MANCHE unchanged). INIZIO=1 restarts as from IDLE.
- Counters never wrap: played cannot exceed max_r, and max_r <= 2^CNT_W-1.

Optional Feature:
NO_REPEAT_EN
- Defined: the previous valid round's winner may not replay its winning move. Such a round is invalid (MANCHE=00, no counter change). Reference move is cleared after a tie, an invalid round, restart and reset.
- Undefined: no repeat restriction, and the last-winner-move register is not instantiated.

Decomposition:
- Package morra_pkg: move_t (NONE, SASSO, CARTA, FORBICE), manche_t and partita_t result codes, state_t (IDLE, PLAY, END).
- Sub-module morra_judge: combinational move-pair -> {valid, result}. Takes the optional forbidden-move input under NO_REPEAT_EN.

Test Plan:
1. Assert rst_n=0 mid-stream, release; apply PRIMO=10, SECONDO=01 with INIZIO=0 -> MANCHE=00, PARTITA=00, stays IDLE.
2. INIZIO=1 with {PRIMO,SECONDO}=0000 (max 4); then four rounds of P1=10 vs P2=01 -> MANCHE=01 each. PARTITA=00 after rounds 1-3, 01 after round 4; further moves ignored.
3. Max 4; rounds P1 win, P2 win (P1=01, P2=10), tie (11/11), tie -> PARTITA=11 after the 4th round.
4. Max 4; round with P1=00, P2=10 -> MANCHE=00, round count unchanged; four more valid rounds are still required to reach the limit.
5. INIZIO=1 after 2 rounds (w1=2) with cfg 0001 -> counters cleared, max 5; next valid round gives played=1, and PARTITA is not set by the old lead.
6. With NO_REPEAT_EN: P1 wins with 11 vs 10, then P1=11 vs P2=01 -> MANCHE=00, w1 unchanged. Without the macro, the same stimulus gives MANCHE=10.
